packet_lane_arbiter: RTL and testbench

PACKET_LANE_ARBITER -- requirements
Module: packet_lane_arbiter

---
 rtl/packet_lane_arbiter.sv | 140 ++++++++++++++
 tb/tb_packet_lane_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_lane_arbiter.sv
// Two-source packet arbiter feeding a single lane FIFO with an HS/LP mode tag per byte.
// Mode changes wait for the lane to drain; granted packets are never preempted.
module packet_lane_arbiter #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter bit          PRIO_LP    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic       src0_valid,
  input  logic       src0_last,
  input  logic [7:0] src0_data,
  output logic       src0_ready,
  input  logic       src1_valid,
  input  logic       src1_last,
  input  logic [7:0] src1_data,
  output logic       src1_ready,
  output logic [7:0] fifo_wdata,
  output logic       fifo_wmode_lp,
  output logic       fifo_write,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  input  logic       lane_active,
  output logic [1:0] gnt,
  output logic       cur_mode_lp,
  output logic       pkt_done
);

  typedef enum logic [1:0] {StIdle, StDrain, StXfer, StGap} state_e;

  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       cur_mode_lp_q, cur_mode_lp_d;
  logic       pkt_done_q, pkt_done_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       last_gnt_q, last_gnt_d;  // 1 = src1 was granted last

  logic       win_lp;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;

  // src1 is the LP source, so the winner index doubles as the winner's mode
  always_comb begin
    win_lp = src1_valid;
    if (!PRIO_LP && src0_valid && src1_valid) begin
      win_lp = ~last_gnt_q;
    end
  end

  always_comb begin
    sel_valid = gnt_q[1] ? src1_valid : src0_valid;
    sel_last  = gnt_q[1] ? src1_last  : src0_last;
    sel_data  = gnt_q[1] ? src1_data  : src0_data;
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    cur_mode_lp_d = cur_mode_lp_q;
    pkt_done_d    = 1'b0;
    gap_cnt_d     = gap_cnt_q;
    last_gnt_d    = last_gnt_q;
    src0_ready    = 1'b0;
    src1_ready    = 1'b0;
    fifo_write    = 1'b0;
    fifo_wdata    = 8'h00;
    fifo_wmode_lp = cur_mode_lp_q;

    unique case (state_q)
      StIdle: begin
        if (arb_en && (src0_valid || src1_valid)) begin
          gnt_d      = win_lp ? 2'b10 : 2'b01;
          last_gnt_d = win_lp;
          state_d    = (win_lp == cur_mode_lp_q) ? StXfer : StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty && !lane_active) begin
          cur_mode_lp_d = gnt_q[1];
          state_d       = StXfer;
        end
      end
      StXfer: begin
        src0_ready = gnt_q[0] & ~fifo_full;
        src1_ready = gnt_q[1] & ~fifo_full;
        fifo_write = (src0_valid & src0_ready) | (src1_valid & src1_ready);
        fifo_wdata = sel_data;
        if (fifo_write && sel_last) begin
          gnt_d      = 2'b00;
          pkt_done_d = 1'b1;
          if (GapLoad == 8'd0) begin
            state_d = StIdle;
          end else begin
            state_d   = StGap;
            gap_cnt_d = GapLoad;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = 8'd0;
          state_d   = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      gnt_q         <= 2'b00;
      cur_mode_lp_q <= 1'b0;
      pkt_done_q    <= 1'b0;
      gap_cnt_q     <= 8'd0;
      last_gnt_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      cur_mode_lp_q <= cur_mode_lp_d;
      pkt_done_q    <= pkt_done_d;
      gap_cnt_q     <= gap_cnt_d;
      last_gnt_q    <= last_gnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign cur_mode_lp = cur_mode_lp_q;
  assign pkt_done    = pkt_done_q;

  // sel_valid is folded into fifo_write through the per-source ready terms
  logic unused_sel;
  assign unused_sel = sel_valid;

endmodule

// File: tb/tb_packet_lane_arbiter.sv
// Directed bench: one arbiter with default parameters and one in round-robin mode
// with no inter-packet gap, each with its own hand-driven sources.
module tb_packet_lane_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arb_en;
  logic       s0v, s0l, s0r, s1v, s1l, s1r;
  logic [7:0] s0d, s1d, fwd;
  logic       fwm, fw, fifo_full, fifo_empty, lane_active;
  logic [1:0] gnt;
  logic       cur_mode, pkt_done;

  logic       r_s0v, r_s0l, r_s0r, r_s1v, r_s1l, r_s1r;
  logic [7:0] r_s0d, r_s1d, r_fwd;
  logic       r_fwm, r_fw;
  logic [1:0] r_gnt;
  logic       r_cur_mode, r_pkt_done;
  logic       r_arb_en = 1'b1;
  logic       r_fifo_full = 1'b0;
  logic       r_fifo_empty = 1'b1;
  logic       r_lane_active = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  packet_lane_arbiter u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arb_en       (arb_en),
    .src0_valid   (s0v),
    .src0_last    (s0l),
    .src0_data    (s0d),
    .src0_ready   (s0r),
    .src1_valid   (s1v),
    .src1_last    (s1l),
    .src1_data    (s1d),
    .src1_ready   (s1r),
    .fifo_wdata   (fwd),
    .fifo_wmode_lp(fwm),
    .fifo_write   (fw),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .lane_active  (lane_active),
    .gnt          (gnt),
    .cur_mode_lp  (cur_mode),
    .pkt_done     (pkt_done)
  );

  packet_lane_arbiter #(
    .GAP_CYCLES(0),
    .PRIO_LP   (1'b0)
  ) u_dut_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .arb_en       (r_arb_en),
    .src0_valid   (r_s0v),
    .src0_last    (r_s0l),
    .src0_data    (r_s0d),
    .src0_ready   (r_s0r),
    .src1_valid   (r_s1v),
    .src1_last    (r_s1l),
    .src1_data    (r_s1d),
    .src1_ready   (r_s1r),
    .fifo_wdata   (r_fwd),
    .fifo_wmode_lp(r_fwm),
    .fifo_write   (r_fw),
    .fifo_full    (r_fifo_full),
    .fifo_empty   (r_fifo_empty),
    .lane_active  (r_lane_active),
    .gnt          (r_gnt),
    .cur_mode_lp  (r_cur_mode),
    .pkt_done     (r_pkt_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pkt [4];
    logic [7:0] wr_q [$];
    logic [1:0] m_gq [$];
    logic [1:0] r_gq [$];
    logic [1:0] m_prev, r_prev;
    int idx, bad_full, bad_mode, bad_pre, bad;
    int m_c0, m_c1, r_c0, r_c1;
    logic full_t;

    rst_n = 1'b0; arb_en = 1'b1;
    s0v = 1'b1; s0l = 1'b0; s0d = 8'h11;
    s1v = 1'b0; s1l = 1'b0; s1d = 8'h00;
    fifo_full = 1'b0; fifo_empty = 1'b1; lane_active = 1'b0;
    r_s0v = 1'b0; r_s0l = 1'b0; r_s0d = 8'h00;
    r_s1v = 1'b0; r_s1l = 1'b0; r_s1d = 8'h00;

    // Reset state, with a request already pending
    repeat (2) tick();
    settle();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_mode", 32'(cur_mode), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_ready0", 32'(s0r), 32'd0);
    check("rst_write", 32'(fw), 32'd0);
    check("rst_rr_gnt", 32'(r_gnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // HS packet 11 22 33 from src0
    settle();
    check("idle_ready0", 32'(s0r), 32'd0);
    tick();
    settle();
    check("a_gnt", 32'(gnt), 32'd1);
    check("a_w0", {22'd0, fw, fwm, fwd}, {22'd0, 1'b1, 1'b0, 8'h11});
    tick();
    s0d = 8'h22;
    settle();
    check("a_w1", {22'd0, fw, fwm, fwd}, {22'd0, 1'b1, 1'b0, 8'h22});
    tick();
    s0d = 8'h33; s0l = 1'b1;
    settle();
    check("a_w2", {22'd0, fw, fwm, fwd}, {22'd0, 1'b1, 1'b0, 8'h33});
    tick();
    // GAP: LP request arrives while the lane is still busy
    s0v = 1'b0; s0l = 1'b0;
    s1v = 1'b1; s1d = 8'hA1; s1l = 1'b1;
    fifo_empty = 1'b0; lane_active = 1'b1;
    settle();
    check("a_pkt_done", 32'(pkt_done), 32'd1);
    check("a_gnt_clr", 32'(gnt), 32'd0);
    check("gap0_ready1", 32'(s1r), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      settle();
      check("gap_ready1", {30'd0, s1r, fw}, 32'd0);
      if (i == 1) check("a_pkt_done_pulse", 32'(pkt_done), 32'd0);
    end
    tick();
    settle();
    check("idle_gnt", 32'(gnt), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      settle();
      check("drain_hold", {28'd0, gnt, s1r, fw}, {28'd0, 2'b10, 1'b0, 1'b0});
      check("drain_mode", 32'(cur_mode), 32'd0);
      tick();
    end
    fifo_empty = 1'b1; lane_active = 1'b0;
    settle();
    check("drain_exit_nowrite", 32'(fw), 32'd0);
    tick();
    settle();
    check("lp_mode", 32'(cur_mode), 32'd1);
    check("lp_write", {22'd0, fw, fwm, fwd}, {22'd0, 1'b1, 1'b1, 8'hA1});
    tick();
    s1v = 1'b0; s1l = 1'b0;

    // 4-byte HS packet under toggling fifo_full; LP request and arb_en drop mid-packet
    pkt[0] = 8'h41; pkt[1] = 8'h42; pkt[2] = 8'h43; pkt[3] = 8'h44;
    idx = 0; bad_full = 0; bad_mode = 0; bad_pre = 0; full_t = 1'b0;
    for (int c = 0; c < 60 && idx < 4; c++) begin
      s0v = 1'b1; s0d = pkt[idx % 4]; s0l = (idx == 3);
      fifo_full = full_t; full_t = ~full_t;
      s1v = (idx >= 1); s1d = 8'hEE; s1l = 1'b1;
      arb_en = (idx < 2);
      settle();
      if (fw) begin
        wr_q.push_back(fwd);
        if (fifo_full) bad_full++;
        if (fwm) bad_mode++;
      end
      if (s1r || (idx >= 1 && gnt != 2'b01)) bad_pre++;
      if (s0v && s0r) idx++;
      tick();
    end
    check("b_done", 32'(idx), 32'd4);
    check("b_nwrites", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("b_order", (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF, 32'(pkt[i]));
    end
    check("b_write_when_full", 32'(bad_full), 32'd0);
    check("b_mode", 32'(bad_mode), 32'd0);
    check("b_preempt", 32'(bad_pre), 32'd0);

    // arb_en low: pending request must not be granted
    s1v = 1'b0; fifo_full = 1'b0;
    s0v = 1'b1; s0d = 8'h55; s0l = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (gnt != 2'b00 || fw) bad++;
      tick();
    end
    check("c_blocked", 32'(bad), 32'd0);
    arb_en = 1'b1;
    settle();
    check("c_idle", 32'(gnt), 32'd0);
    tick();
    settle();
    check("c_gnt", 32'(gnt), 32'd1);
    check("c_write", {23'd0, fw, fwd}, {23'd0, 1'b1, 8'h55});
    tick();
    s0v = 1'b0; s0l = 1'b0;

    // LP packet interrupted by reset after its second byte
    idx = 0;
    for (int c = 0; c < 40 && idx < 2; c++) begin
      s1v = 1'b1; s1d = pkt[idx % 4]; s1l = (idx == 3);
      settle();
      if (s1v && s1r) idx++;
      tick();
    end
    check("d_two_bytes", 32'(idx), 32'd2);
    s1d = pkt[2];
    #2;
    check("d_pre_rst", {29'd0, gnt, cur_mode}, {29'd0, 2'b10, 1'b1});
    rst_n = 1'b0;
    #1;
    check("d_rst_gnt", 32'(gnt), 32'd0);
    check("d_rst_mode", 32'(cur_mode), 32'd0);
    check("d_rst_ready", {30'd0, s0r, s1r}, 32'd0);
    check("d_rst_write", 32'(fw), 32'd0);
    tick();
    s1v = 1'b0;
    rst_n = 1'b1;
    settle();
    check("d_after_gnt", 32'(gnt), 32'd0);
    tick();

    // Both sources always valid, 2-byte packets
    s0v = 1'b1; s1v = 1'b1; r_s0v = 1'b1; r_s1v = 1'b1;
    m_c0 = 0; m_c1 = 0; r_c0 = 0; r_c1 = 0;
    m_prev = 2'b00; r_prev = 2'b00;
    for (int c = 0; c < 70; c++) begin
      s0l = m_c0[0]; s0d = 8'(m_c0); s1l = m_c1[0]; s1d = 8'(m_c1);
      r_s0l = r_c0[0]; r_s0d = 8'(r_c0); r_s1l = r_c1[0]; r_s1d = 8'(r_c1);
      settle();
      if (gnt != 2'b00 && m_prev == 2'b00) m_gq.push_back(gnt);
      if (r_gnt != 2'b00 && r_prev == 2'b00) r_gq.push_back(r_gnt);
      m_prev = gnt; r_prev = r_gnt;
      if (s0v && s0r) m_c0++;
      if (s1v && s1r) m_c1++;
      if (r_s0v && r_s0r) r_c0++;
      if (r_s1v && r_s1r) r_c1++;
      tick();
    end
    check("e_prio_ngrants", 32'(m_gq.size() >= 4), 32'd1);
    check("e_prio_src0_bytes", 32'(m_c0), 32'd0);
    for (int i = 0; i < 4 && i < m_gq.size(); i++) begin
      check("e_prio_order", 32'(m_gq[i]), 32'd2);
    end
    check("e_rr_ngrants", 32'(r_gq.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < r_gq.size(); i++) begin
      check("e_rr_order", 32'(r_gq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
